// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage and imem.
// imem_req_o and imem_addr_o stay stable from the cycle req rises through the cycle with imem_ack_i=1.
// imem_data_i is valid only when imem_ack_i=1. An ack with req=0 has no effect, and ack may rise in the request cycle.
interface if_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;

  modport master (output imem_req_o, imem_addr_o, input imem_ack_i, imem_data_i);
  modport slave  (input imem_req_o, imem_addr_o, output imem_ack_i, imem_data_i);
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: PC, imem handshake, one-entry skid buffer and the IF/ID register, with branch redirect and stall.
// Optional macro IF_PERF_CNT_EN adds the stall_cnt_o stall-cycle counter.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_addr_i,
  if_fetch_unit_if.master imem,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
`endif
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d;
  logic        kill_q, kill_d;
  logic [31:0] skid_q, skid_d, skid_pc_q, skid_pc_d;
  logic        ifid_valid_d;
  logic [31:0] ifid_pc_d, ifid_instr_d;
  logic        req, ack;
  logic [31:0] target;

  assign req    = (state_q == REQ);
  assign ack    = req & imem.imem_ack_i;
  assign target = branch_addr_i & ~32'h3;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = addr_q;
  assign dbg_state_o      = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      kill_q       <= 1'b0;
      skid_q       <= NOP_INSTR;
      skid_pc_q    <= 32'h0;
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= 32'h0;
      ifid_instr_o <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      kill_q       <= kill_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      ifid_valid_o <= ifid_valid_d;
      ifid_pc_o    <= ifid_pc_d;
      ifid_instr_o <= ifid_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    kill_d       = kill_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    ifid_valid_d = ifid_valid_o;
    ifid_pc_d    = ifid_pc_o;
    ifid_instr_d = ifid_instr_o;
    if (flush_i) begin
      ifid_valid_d = 1'b0;
      ifid_pc_d    = 32'h0;
      ifid_instr_d = NOP_INSTR;
      pc_d         = target;
      // An unacked request must finish at its old address; its word is dropped via kill.
      kill_d       = req & ~imem.imem_ack_i;
      if (req && !imem.imem_ack_i) begin
        state_d = REQ;
      end else if (start_i) begin
        state_d = REQ;
        addr_d  = target;
      end else begin
        state_d = IDLE;
      end
    end else begin
      // Unless frozen, the decoder sees a bubble in any cycle without a new word.
      if (!stall_i) begin
        ifid_valid_d = 1'b0;
        ifid_pc_d    = 32'h0;
        ifid_instr_d = NOP_INSTR;
      end
      unique case (state_q)
        IDLE: begin
          if (start_i && !stall_i) begin
            state_d = REQ;
            addr_d  = pc_q;
          end
        end
        REQ: begin
          if (ack) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = (start_i && !stall_i) ? REQ : IDLE;
              addr_d  = pc_q;
            end else if (stall_i) begin
              skid_d    = imem.imem_data_i;
              skid_pc_d = addr_q;
              pc_d      = pc_q + 32'd4;
              state_d   = HOLD;
            end else begin
              ifid_valid_d = 1'b1;
              ifid_pc_d    = addr_q;
              ifid_instr_d = imem.imem_data_i;
              pc_d         = pc_q + 32'd4;
              state_d      = start_i ? REQ : IDLE;
              addr_d       = pc_q + 32'd4;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = skid_pc_q;
            ifid_instr_d = skid_q;
            state_d      = start_i ? REQ : IDLE;
            addr_d       = pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'h0;
    end else if (start_i && stall_i && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
